// File: rtl/octal_sub_seq.sv
// Bit-serial sequencer driving one external full-subtractor cell, LSB first,
// with the borrow chained through a register and a start/busy/done handshake.
module octal_sub_seq #(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [3*DIGITS-1:0]   i_a,
   input  logic [3*DIGITS-1:0]   i_b,
   output logic                  o_fs_a,
   output logic                  o_fs_b,
   output logic                  o_fs_cin,
   input  logic                  i_fs_diff,
   input  logic                  i_fs_borrow,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [3*DIGITS-1:0]   o_diff,
   output logic                  o_borrow_out
);

   localparam int unsigned W  = 3 * DIGITS;
   localparam int unsigned CW = $clog2(W + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t          r_state, w_state_nxt;
   logic [W-1:0]    r_a_sh, r_b_sh, r_sh, r_diff;
   logic [W-1:0]    w_a_nxt, w_b_nxt, w_sh_nxt, w_diff_nxt;
   logic            r_brw, w_brw_nxt;
   logic            r_borrow, w_borrow_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic            w_accept;
   logic            r_busy, r_done, r_fs_a, r_fs_b, r_fs_cin;

   // Next-state and datapath update
   always_comb begin
      w_state_nxt  = r_state;
      w_a_nxt      = r_a_sh;
      w_b_nxt      = r_b_sh;
      w_sh_nxt     = r_sh;
      w_brw_nxt    = r_brw;
      w_cnt_nxt    = r_cnt;
      w_diff_nxt   = r_diff;
      w_borrow_nxt = r_borrow;
      w_accept     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_accept = i_start;
         end
         S_SHIFT: begin
            w_sh_nxt  = W'({i_fs_diff, r_sh} >> 1);
            w_brw_nxt = i_fs_borrow;
            w_a_nxt   = r_a_sh >> 1;
            w_b_nxt   = r_b_sh >> 1;
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_cnt == CW'(W - 1)) begin
               w_diff_nxt   = w_sh_nxt;
               w_borrow_nxt = i_fs_borrow;
               w_state_nxt  = S_DONE;
            end
         end
         S_DONE: begin
            w_accept    = i_start;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Acceptance is identical from IDLE and DONE so starts can run back to back
      if (w_accept) begin
         w_a_nxt     = i_a;
         w_b_nxt     = i_b;
         w_brw_nxt   = 1'b0;
         w_cnt_nxt   = '0;
         w_state_nxt = S_SHIFT;
      end
   end

   // State, datapath and registered outputs (outputs follow the next state)
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_sh     <= '0;
         r_brw    <= 1'b0;
         r_cnt    <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_fs_a   <= 1'b0;
         r_fs_b   <= 1'b0;
         r_fs_cin <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_a_sh   <= w_a_nxt;
         r_b_sh   <= w_b_nxt;
         r_sh     <= w_sh_nxt;
         r_brw    <= w_brw_nxt;
         r_cnt    <= w_cnt_nxt;
         r_diff   <= w_diff_nxt;
         r_borrow <= w_borrow_nxt;
         r_busy   <= (w_state_nxt == S_SHIFT);
         r_done   <= (w_state_nxt == S_DONE);
         r_fs_a   <= (w_state_nxt == S_SHIFT) & w_a_nxt[0];
         r_fs_b   <= (w_state_nxt == S_SHIFT) & w_b_nxt[0];
         r_fs_cin <= (w_state_nxt == S_SHIFT) & w_brw_nxt;
      end
   end

   assign o_fs_a       = r_fs_a;
   assign o_fs_b       = r_fs_b;
   assign o_fs_cin     = r_fs_cin;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_diff       = r_diff;
   assign o_borrow_out = r_borrow;

endmodule

// File: tb/tb_octal_sub_seq.sv
// Self-checking bench for octal_sub_seq with a behavioural full_sub cell and
// an arithmetic reference model for the difference, borrow and bit timing.
module tb_octal_sub_seq;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned W      = 3 * DIGITS;
   localparam int          MODW   = 1 << W;

   logic          clk = 1'b0;
   logic          i_rst, i_start;
   logic [W-1:0]  i_a, i_b;
   logic          o_fs_a, o_fs_b, o_fs_cin;
   logic          i_fs_diff, i_fs_borrow;
   logic          o_busy, o_done, o_borrow_out;
   logic [W-1:0]  o_diff;

   int            errors = 0;
   int            checks = 0;
   logic [W-1:0]  prev_diff = '0;
   logic          prev_bo   = 1'b0;

   always #5 clk = ~clk;

   // External one-bit full subtractor
   assign i_fs_diff   = o_fs_a ^ o_fs_b ^ o_fs_cin;
   assign i_fs_borrow = (~o_fs_a & o_fs_b) | (~(o_fs_a ^ o_fs_b) & o_fs_cin);

   octal_sub_seq #(.DIGITS(DIGITS)) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_start      (i_start),
      .i_a          (i_a),
      .i_b          (i_b),
      .o_fs_a       (o_fs_a),
      .o_fs_b       (o_fs_b),
      .o_fs_cin     (o_fs_cin),
      .i_fs_diff    (i_fs_diff),
      .i_fs_borrow  (i_fs_borrow),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_diff       (o_diff),
      .o_borrow_out (o_borrow_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full operation; inj>0 pulses a stray start (a=0o1111) at that busy cycle
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
      int           lat;
      int           bcnt;
      logic [W-1:0] ed;
      logic [W-1:0] mask;
      logic         eb;
      ed   = W'((int'(a) - int'(b) + MODW) % MODW);
      eb   = (a < b);
      lat  = -1;
      bcnt = 0;
      @(negedge clk);
      i_a = a; i_b = b; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_a = W'($urandom);
      i_b = W'($urandom);
      for (int n = 1; n <= 40; n++) begin
         if (o_done) begin
            lat = n;
            break;
         end
         if (n == 2) begin
            chk("diff_hold", 32'(o_diff), 32'(prev_diff));
            chk("borrow_hold", 32'(o_borrow_out), 32'(prev_bo));
         end
         if (o_busy) begin
            bcnt++;
            mask = W'((1 << (n - 1)) - 1);
            chk("fs_a_bit", 32'(o_fs_a), 32'(a[(n-1) % W]));
            chk("fs_b_bit", 32'(o_fs_b), 32'(b[(n-1) % W]));
            chk("fs_cin_bit", 32'(o_fs_cin), 32'((a & mask) < (b & mask)));
         end else begin
            chk("fs_idle_zero", 32'({o_fs_a, o_fs_b, o_fs_cin}), 32'(0));
         end
         if (n == inj) begin
            i_start = 1'b1; i_a = 12'o1111; i_b = '0;
         end else if (n == inj + 1) begin
            i_start = 1'b0;
         end
         @(negedge clk);
      end
      i_start = 1'b0;
      chk("latency", 32'(lat), 32'(W + 1));
      chk("busy_cycles", 32'(bcnt), 32'(W));
      chk("diff", 32'(o_diff), 32'(ed));
      chk("borrow_out", 32'(o_borrow_out), 32'(eb));
      @(negedge clk);
      chk("done_one_cycle", 32'(o_done), 32'(0));
      chk("diff_after_done", 32'(o_diff), 32'(ed));
      prev_diff = ed;
      prev_bo   = eb;
   endtask

   initial begin
      int d[3];
      int nd;
      int stray;
      i_rst = 1'b1; i_start = 1'b0; i_a = '0; i_b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(o_busy), 32'(0));
      chk("rst_done", 32'(o_done), 32'(0));
      chk("rst_diff", 32'(o_diff), 32'(0));
      chk("rst_borrow", 32'(o_borrow_out), 32'(0));
      chk("rst_fs", 32'({o_fs_a, o_fs_b, o_fs_cin}), 32'(0));
      i_rst = 1'b0;

      run_op(12'o7654, 12'o1234, -1);
      chk("plan_7654_1234", 32'(o_diff), 32'(12'o6420));
      run_op(12'o0000, 12'o0001, -1);
      chk("plan_0_1_diff", 32'(o_diff), 32'(12'o7777));
      chk("plan_0_1_borrow", 32'(o_borrow_out), 32'(1));
      run_op(12'o5555, 12'o5555, -1);
      chk("plan_equal", 32'(o_diff), 32'(0));

      // Stray start while busy must be ignored
      run_op(12'o4321, 12'o0123, 4);

      // start held high: back-to-back operations
      nd = 0;
      @(negedge clk);
      i_a = 12'o0010; i_b = 12'o0007; i_start = 1'b1;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (o_done) begin
            d[nd] = n;
            nd++;
            chk("held_diff", 32'(o_diff), 32'(1));
            chk("held_borrow", 32'(o_borrow_out), 32'(0));
            if (nd == 3) begin
               i_start = 1'b0;
               break;
            end
         end
      end
      i_start = 1'b0;
      chk("held_count", 32'(nd), 32'(3));
      if (nd == 3) begin
         chk("held_gap1", 32'(d[1] - d[0]), 32'(W + 1));
         chk("held_gap2", 32'(d[2] - d[1]), 32'(W + 1));
      end
      @(negedge clk);
      chk("held_stop_busy", 32'(o_busy), 32'(0));
      prev_diff = 12'o0001;
      prev_bo   = 1'b0;

      // Reset in the middle of an operation
      @(negedge clk);
      i_a = 12'o3333; i_b = 12'o1111; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (5) @(negedge clk);
      i_rst = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      chk("midrst_busy", 32'(o_busy), 32'(0));
      chk("midrst_done", 32'(o_done), 32'(0));
      chk("midrst_diff", 32'(o_diff), 32'(0));
      chk("midrst_borrow", 32'(o_borrow_out), 32'(0));
      chk("midrst_fs", 32'({o_fs_a, o_fs_b, o_fs_cin}), 32'(0));
      stray = 0;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (o_done || o_busy) stray++;
      end
      chk("midrst_no_done", 32'(stray), 32'(0));
      prev_diff = '0;
      prev_bo   = 1'b0;
      run_op(12'o3333, 12'o1111, -1);

      // Randomized operands against the arithmetic model
      for (int k = 0; k < 1000; k++) begin
         run_op(W'($urandom), W'($urandom), -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
